dmem_port_arbiter: RTL and testbench

- Shares the single data-memory RAM port between two requesters:
  - the core load/store path (MEM stage);
  - an external requester (debug loader / DMA).
- Fixed core priority, with a starvation counter that guarantees forward progress for the external side.
- Drives RAM byte-lane write enables and word address.
- Tracks which requester owns each in-flight read so that 1-cycle-latency read data is returned to the correct side.

---
 rtl/dmem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core MEM stage vs external requester.
// Optional misalignment check enabled by DMEM_ARB_ALIGN_CHECK_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int MAX_CORE_WINS = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [3:0]        core_be,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    input  logic [3:0]        ext_be,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    ,
    output logic              core_err,
    output logic              ext_err
`endif
);

    localparam logic [3:0] MAX_W = 4'(MAX_CORE_WINS);

    logic [3:0]  win_cnt;
    logic        pend;
    logic        owner;
    logic        contend;
    logic        ext_turn;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        mis;
    logic        issue;
    logic        rd_issue;

    assign contend  = core_req & ext_req;
    assign ext_turn = contend & (win_cnt == MAX_W);

    always_comb begin
        core_gnt = Reset_n & core_req & ~ext_turn;
        ext_gnt  = Reset_n & ext_req & (~core_req | ext_turn);
    end

    assign core_stall = core_req & ~core_gnt;

    // Idle port keeps the core path selected; address/data are don't-care then.
    always_comb begin
        sel_we    = core_we;
        sel_be    = core_be;
        sel_addr  = core_addr;
        sel_wdata = core_wdata;
        if (ext_gnt) begin
            sel_we    = ext_we;
            sel_be    = ext_be;
            sel_addr  = ext_addr;
            sel_wdata = ext_wdata;
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    function automatic logic be_ok(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default:                   be_ok = 1'b0;
        endcase
    endfunction

    assign mis = (sel_addr[1:0] != 2'b00) | ~be_ok(sel_be);
`else
    assign mis = 1'b0;
`endif

    assign issue    = (core_gnt | ext_gnt) & ~mis;
    assign rd_issue = issue & ~sel_we;

    always_comb begin
        ram_en    = issue;
        ram_we    = 4'b0000;
        ram_addr  = sel_addr[ADDR_W+1:2];
        ram_wdata = sel_wdata;
        if (issue && sel_we)
            ram_we = sel_be;
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pend    <= 1'b0;
            owner   <= 1'b0;
            win_cnt <= 4'd0;
        end else begin
            pend    <= rd_issue;
            owner   <= ext_gnt;
            win_cnt <= (contend && win_cnt < MAX_W) ? win_cnt + 4'd1 : 4'd0;
        end
    end

    // Gated by Reset_n so a read caught by reset never returns.
    assign core_rvalid = Reset_n & pend & ~owner;
    assign ext_rvalid  = Reset_n & pend & owner;
    assign core_rdata  = ram_rdata;
    assign ext_rdata   = ram_rdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            core_err <= 1'b0;
            ext_err  <= 1'b0;
        end else begin
            core_err <= core_gnt & mis;
            ext_err  <= ext_gnt & mis;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Table-driven bench with read-return scoreboard and behavioural RAM.
// Covers DMEM_ARB_ALIGN_CHECK_EN when the macro is defined.
module tb_dmem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        core_req, core_we, ext_req, ext_we;
    logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
    logic [3:0]  core_be, ext_be;
    logic        core_gnt, core_stall, core_rvalid, ext_gnt, ext_rvalid;
    logic [31:0] core_rdata, ext_rdata, ram_wdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic        core_err, ext_err;
`endif

    always #5 Clk = ~Clk;

    dmem_port_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_be(core_be), .core_gnt(core_gnt),
        .core_stall(core_stall), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_be(ext_be), .ext_gnt(ext_gnt),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        , .core_err(core_err), .ext_err(ext_err)
`endif
    );

    logic [31:0] mem [4096];
    logic [31:0] shadow [4096];

    always @(posedge Clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
    end

    typedef struct {
        logic cr, cw; logic [31:0] ca; logic [3:0] cb; logic [31:0] cd;
        logic er, ew; logic [31:0] ea; logic [3:0] eb; logic [31:0] ed;
        logic xcg, xeg; logic [3:0] xwe; logic [11:0] xaddr;
    } vec_t;

    typedef struct {
        logic cv, ev, cerr, eerr; logic [31:0] d;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic ok_shape(input logic [31:0] a,
                                      input logic [3:0] be);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        logic s;
        s = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) ||
            (be == 4'b1000) || (be == 4'b0011) || (be == 4'b1100) ||
            (be == 4'b1111);
        return s && (a[1:0] == 2'b00);
`else
        return (a[0] === a[0]) && (be === be);
`endif
    endfunction

    task automatic add(
        input logic cr, cw, input logic [31:0] ca, input logic [3:0] cb,
        input logic [31:0] cd,
        input logic er, ew, input logic [31:0] ea, input logic [3:0] eb,
        input logic [31:0] ed,
        input logic xcg, xeg, input logic [3:0] xwe, input logic [11:0] xa);
        vec_t v;
        v = '{cr, cw, ca, cb, cd, er, ew, ea, eb, ed, xcg, xeg, xwe, xa};
        vt.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        core_req = v.cr; core_we = v.cw; core_addr = v.ca;
        core_be = v.cb; core_wdata = v.cd;
        ext_req = v.er; ext_we = v.ew; ext_addr = v.ea;
        ext_be = v.eb; ext_wdata = v.ed;
    endtask

    task automatic idle();
        vec_t v;
        v = '{0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 12'h0};
        drive(v);
    endtask

    task automatic check_ret();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("core_rvalid", {31'd0, core_rvalid}, {31'd0, e.cv});
        chk("ext_rvalid", {31'd0, ext_rvalid}, {31'd0, e.ev});
        if (e.cv) chk("core_rdata", core_rdata, e.d);
        if (e.ev) chk("ext_rdata", ext_rdata, e.d);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        chk("core_err", {31'd0, core_err}, {31'd0, e.cerr});
        chk("ext_err", {31'd0, ext_err}, {31'd0, e.eerr});
`endif
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        logic ok, en, we;
        logic [3:0] be;
        logic [31:0] wd;
        @(negedge Clk);
        drive(v);
        #2;
        ok = v.xeg ? ok_shape(v.ea, v.eb) : ok_shape(v.ca, v.cb);
        en = (v.xcg | v.xeg) & ok;
        we = v.xeg ? v.ew : v.cw;
        be = v.xeg ? v.eb : v.cb;
        wd = v.xeg ? v.ed : v.cd;
        chk("core_gnt", {31'd0, core_gnt}, {31'd0, v.xcg});
        chk("ext_gnt", {31'd0, ext_gnt}, {31'd0, v.xeg});
        chk("core_stall", {31'd0, core_stall}, {31'd0, v.cr & ~v.xcg});
        chk("ram_en", {31'd0, ram_en}, {31'd0, en});
        chk("ram_we", {28'd0, ram_we}, {28'd0, en ? v.xwe : 4'h0});
        if (en) chk("ram_addr", {20'd0, ram_addr}, {20'd0, v.xaddr});
        if (en && we) chk("ram_wdata", ram_wdata, wd);
        check_ret();
        e.cv = v.xcg & ~v.cw & ok;
        e.ev = v.xeg & ~v.ew & ok;
        e.cerr = v.xcg & ~ok;
        e.eerr = v.xeg & ~ok;
        e.d = shadow[v.xaddr];
        sb.push_back(e);
        if (en && we)
            for (int b = 0; b < 4; b++)
                if (be[b]) shadow[v.xaddr][b*8 +: 8] = wd[b*8 +: 8];
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'hC0DE_0000 + i * 32'h0001_0003;
            shadow[i] = mem[i];
        end
        ram_rdata = 32'h0;

        add(1,0,32'h10,4'hF,0, 0,0,0,4'h0,0, 1,0,4'h0,12'd4);
        add(0,0,0,4'h0,0, 0,0,0,4'h0,0, 0,0,4'h0,12'd0);
        add(0,0,0,4'h0,0, 1,1,32'h20,4'h3,32'hDEADBEEF, 0,1,4'h3,12'd8);
        add(0,0,0,4'h0,0, 0,0,0,4'h0,0, 0,0,4'h0,12'd0);
        add(1,0,32'h20,4'hF,0, 0,0,0,4'h0,0, 1,0,4'h0,12'd8);
        add(1,0,32'h4,4'hF,0, 0,0,0,4'h0,0, 1,0,4'h0,12'd1);
        add(0,0,0,4'h0,0, 1,0,32'h8,4'hF,0, 0,1,4'h0,12'd2);
        add(0,0,0,4'h0,0, 0,0,0,4'h0,0, 0,0,4'h0,12'd0);
        for (int i = 0; i < 10; i++)
            add(1,0,32'h40,4'hF,0, 1,0,32'h80,4'hF,0,
                (i % 5) != 4, (i % 5) == 4, 4'h0,
                ((i % 5) == 4) ? 12'd32 : 12'd16);
        add(0,0,0,4'h0,0, 1,0,32'h100,4'hF,0, 0,1,4'h0,12'd64);
        add(1,1,32'h100,4'hF,32'h12345678, 0,0,0,4'h0,0, 1,0,4'hF,12'd64);
        add(1,0,32'h100,4'hF,0, 0,0,0,4'h0,0, 1,0,4'h0,12'd64);
        add(1,1,32'hC,4'h0,32'h55AA55AA, 0,0,0,4'h0,0, 1,0,4'h0,12'd3);
        add(0,1,32'h10,4'hF,32'h0, 0,0,0,4'h0,0, 0,0,4'h0,12'd0);
        add(1,0,32'hFFFF_FFFC,4'hF,0, 0,0,0,4'h0,0, 1,0,4'h0,12'hFFF);
        add(0,0,0,4'h0,0, 1,0,32'h3FFC,4'hF,0, 0,1,4'h0,12'hFFF);
        add(0,0,0,4'h0,0, 0,0,0,4'h0,0, 0,0,4'h0,12'd0);

        // Reset with both sides requesting: nothing may be issued.
        Reset_n = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0;
        core_be = 4'hF; core_wdata = 32'h0;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h4;
        ext_be = 4'hF; ext_wdata = 32'h0;
        repeat (2) @(negedge Clk);
        #2;
        chk("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
        chk("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
        chk("rst_rvalid", {30'd0, core_rvalid, ext_rvalid}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        idle();
        sb.push_back('{0, 0, 0, 0, 32'h0});

        foreach (vt[k]) run_vec(vt[k]);

        // Reset mid-read while the counter is non-zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
            core_be = 4'hF;
            ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h80;
            ext_be = 4'hF;
            #2;
            chk("pre_rst_core_gnt", {31'd0, core_gnt}, 32'd1);
        end
        @(negedge Clk);
        Reset_n = 1'b0;
        #2;
        chk("rst_n1_core_rvalid", {31'd0, core_rvalid}, 32'd0);
        chk("rst_n1_ram_en", {31'd0, ram_en}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        #2;
        chk("rst_n2_core_rvalid", {31'd0, core_rvalid}, 32'd0);
        chk("rst_n2_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge Clk);
                #2;
            end
            chk("post_rst_core_gnt", {31'd0, core_gnt}, {31'd0, i != 4});
            chk("post_rst_ext_gnt", {31'd0, ext_gnt}, {31'd0, i == 4});
        end
        @(negedge Clk);
        idle();

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        @(negedge Clk);
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h6;
        core_be = 4'hF; core_wdata = 32'h1;
        #2;
        chk("mis_core_gnt", {31'd0, core_gnt}, 32'd1);
        chk("mis_ram_en", {31'd0, ram_en}, 32'd0);
        @(negedge Clk);
        idle();
        #2;
        chk("mis_core_err", {31'd0, core_err}, 32'd1);
        @(negedge Clk);
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h8; ext_be = 4'b0110;
        #2;
        chk("mis_ext_gnt", {31'd0, ext_gnt}, 32'd1);
        chk("mis_rd_ram_en", {31'd0, ram_en}, 32'd0);
        @(negedge Clk);
        idle();
        #2;
        chk("mis_ext_err", {31'd0, ext_err}, 32'd1);
        chk("mis_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
        @(negedge Clk);
        #2;
        chk("mis_err_pulse", {30'd0, core_err, ext_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
